// File: rtl/wb_axis_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb_axis_bridge
// Description : Wishbone classic slave that tunnels 16-bit accesses over a
//               byte-wide command/response AXI-Stream pair, with an address
//               shadow that compresses repeated or nearby addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_axis_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int POSTINC    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_cyc,
    input  logic                  wb_stb,
    input  logic                  wb_we,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [15:0]           wb_data_write,
    output logic [15:0]           wb_data_read,
    output logic                  wb_ack,
    output logic                  wb_err,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic [7:0]            m_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic [7:0]            s_axis_data,
    output logic                  overflow
);

    localparam logic [7:0] c_postinc = (POSTINC != 0) ? 8'd1 : 8'd0;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CMD      = 4'd1,
        ADDR     = 4'd2,
        WDATA_HI = 4'd3,
        WDATA_LO = 4'd4,
        STATUS   = 4'd5,
        RDATA_LO = 4'd6,
        RDATA_HI = 4'd7,
        DONE     = 4'd8
    } state_t;

    state_t                r_state,      w_state_nxt;
    logic [1:0]            r_cnt,        w_cnt_nxt;
    logic                  r_we,         w_we_nxt;
    logic [15:0]           r_wdata,      w_wdata_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,       w_addr_nxt;
    logic [1:0]            r_code,       w_code_nxt;
    logic [ADDR_WIDTH-1:0] r_shadow,     w_shadow_nxt;
    logic                  r_shadow_vld, w_shadow_vld_nxt;
    logic                  r_m_valid,    w_m_valid_nxt;
    logic [7:0]            r_m_data,     w_m_data_nxt;
    logic                  r_s_ready,    w_s_ready_nxt;
    logic [7:0]            r_rdata_lo,   w_rdata_lo_nxt;
    logic [15:0]           r_rdata,      w_rdata_nxt;
    logic                  r_ack,        w_ack_nxt;
    logic                  r_err,        w_err_nxt;
    logic                  r_ovf,        w_ovf_nxt;
    logic                  r_stat_ovf,   w_stat_ovf_nxt;
    logic                  r_abort,      w_abort_nxt;

    logic        w_req, w_accept, w_m_fire, w_s_fire, w_abort_now;
    logic        w_match_hi8, w_match_hi16;
    logic [1:0]  w_code_req, w_cnt_start;
    logic [31:0] w_addr32;
    logic [7:0]  w_addr_byte_cur, w_addr_byte_dec;
    logic        w_stat_proto, w_stat_good;
    logic        w_payload, w_finish, w_fin_good, w_fin_ovf;

    generate
        if (!(ADDR_WIDTH == 8 || ADDR_WIDTH == 16 || ADDR_WIDTH == 24 || ADDR_WIDTH == 32)) begin : g_bad_addr_width
            $error("wb_axis_bridge: ADDR_WIDTH must be 8, 16, 24 or 32");
        end
        if (ADDR_WIDTH > 8) begin : g_hi8
            assign w_match_hi8 = (wb_addr[ADDR_WIDTH-1:8] == r_shadow[ADDR_WIDTH-1:8]);
        end else begin : g_no_hi8
            assign w_match_hi8 = 1'b1;
        end
        if (ADDR_WIDTH > 16) begin : g_hi16
            assign w_match_hi16 = (wb_addr[ADDR_WIDTH-1:16] == r_shadow[ADDR_WIDTH-1:16]);
        end else begin : g_no_hi16
            assign w_match_hi16 = 1'b0;
        end
    endgenerate

    assign w_req       = wb_cyc && wb_stb;
    assign w_accept    = (r_state == IDLE) && w_req && !r_ack && !r_err;
    assign w_m_fire    = r_m_valid && m_axis_ready;
    assign w_s_fire    = r_s_ready && s_axis_valid;
    assign w_abort_now = r_abort || !w_req;

    assign w_addr32        = 32'(r_addr);
    assign w_addr_byte_cur = w_addr32[{r_cnt, 3'b000} +: 8];
    assign w_addr_byte_dec = w_addr32[{r_cnt - 2'd1, 3'b000} +: 8];

    assign w_stat_proto = (s_axis_data[0] != r_we) || (s_axis_data[7:4] != 4'd0) || s_axis_data[2];
    assign w_stat_good  = !w_stat_proto && !s_axis_data[1];

    always_comb begin
        if (!r_shadow_vld) begin
            w_code_req = 2'd3;
        end else if (wb_addr == r_shadow) begin
            w_code_req = 2'd0;
        end else if (w_match_hi8) begin
            w_code_req = 2'd1;
        end else if (w_match_hi16) begin
            w_code_req = 2'd2;
        end else begin
            w_code_req = 2'd3;
        end
    end

    // Address bytes go out MSB first; the counter names the byte still to send
    assign w_cnt_start = (w_code_req == 2'd3) ? 2'd3 : ((w_code_req == 2'd2) ? 2'd1 : 2'd0);

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_we_nxt         = r_we;
        w_wdata_nxt      = r_wdata;
        w_addr_nxt       = r_addr;
        w_code_nxt       = r_code;
        w_shadow_nxt     = r_shadow;
        w_shadow_vld_nxt = r_shadow_vld;
        w_m_valid_nxt    = r_m_valid;
        w_m_data_nxt     = r_m_data;
        w_s_ready_nxt    = r_s_ready;
        w_rdata_lo_nxt   = r_rdata_lo;
        w_rdata_nxt      = r_rdata;
        w_stat_ovf_nxt   = r_stat_ovf;
        w_abort_nxt      = r_abort;
        w_ack_nxt        = 1'b0;
        w_err_nxt        = 1'b0;
        w_ovf_nxt        = 1'b0;
        w_payload        = 1'b0;
        w_finish         = 1'b0;
        w_fin_good       = 1'b0;
        w_fin_ovf        = 1'b0;

        if (r_state != IDLE && !w_req) begin
            w_abort_nxt = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = CMD;
                    w_we_nxt      = wb_we;
                    w_wdata_nxt   = wb_data_write;
                    w_addr_nxt    = wb_addr;
                    w_code_nxt    = w_code_req;
                    w_cnt_nxt     = w_cnt_start;
                    w_abort_nxt   = 1'b0;
                    w_m_valid_nxt = 1'b1;
                    w_m_data_nxt  = {3'b000, w_code_req, c_postinc[0], wb_we, 1'b0};
                end
            end
            CMD: begin
                if (w_m_fire) begin
                    w_shadow_nxt     = r_addr;
                    w_shadow_vld_nxt = 1'b1;
                    if (r_code != 2'd0) begin
                        w_state_nxt  = ADDR;
                        w_m_data_nxt = w_addr_byte_cur;
                    end else begin
                        w_payload = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (w_m_fire) begin
                    if (r_cnt != 2'd0) begin
                        w_cnt_nxt    = r_cnt - 2'd1;
                        w_m_data_nxt = w_addr_byte_dec;
                    end else begin
                        w_payload = 1'b1;
                    end
                end
            end
            WDATA_HI: begin
                if (w_m_fire) begin
                    w_state_nxt  = WDATA_LO;
                    w_m_data_nxt = r_wdata[7:0];
                end
            end
            WDATA_LO: begin
                if (w_m_fire) begin
                    w_state_nxt   = STATUS;
                    w_m_valid_nxt = 1'b0;
                    w_s_ready_nxt = 1'b1;
                end
            end
            STATUS: begin
                if (w_s_fire) begin
                    w_stat_ovf_nxt = s_axis_data[3];
                    if (w_stat_good && !r_we) begin
                        w_state_nxt = RDATA_LO;
                    end else begin
                        w_finish   = 1'b1;
                        w_fin_good = w_stat_good;
                        w_fin_ovf  = s_axis_data[3];
                    end
                end
            end
            RDATA_LO: begin
                if (w_s_fire) begin
                    w_rdata_lo_nxt = s_axis_data;
                    w_state_nxt    = RDATA_HI;
                end
            end
            RDATA_HI: begin
                if (w_s_fire) begin
                    w_rdata_nxt = {s_axis_data, r_rdata_lo};
                    w_finish    = 1'b1;
                    w_fin_good  = 1'b1;
                    w_fin_ovf   = r_stat_ovf;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_payload) begin
            if (r_we) begin
                w_state_nxt  = WDATA_HI;
                w_m_data_nxt = r_wdata[15:8];
            end else begin
                w_state_nxt   = STATUS;
                w_m_valid_nxt = 1'b0;
                w_s_ready_nxt = 1'b1;
            end
        end

        // A dropped Wishbone request still completes the exchange and keeps
        // the shadow coherent with the remote; only the handshake is muted
        if (w_finish) begin
            w_state_nxt   = DONE;
            w_s_ready_nxt = 1'b0;
            w_ack_nxt     = w_fin_good && !w_abort_now;
            w_err_nxt     = !w_fin_good && !w_abort_now;
            w_ovf_nxt     = w_fin_ovf;
            if (w_fin_good) begin
                w_shadow_nxt[7:0] = r_shadow[7:0] + c_postinc;
            end else begin
                w_shadow_vld_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= 2'd0;
            r_we         <= 1'b0;
            r_wdata      <= 16'd0;
            r_addr       <= '0;
            r_code       <= 2'd0;
            r_shadow     <= '0;
            r_shadow_vld <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_data     <= 8'd0;
            r_s_ready    <= 1'b0;
            r_rdata_lo   <= 8'd0;
            r_rdata      <= 16'd0;
            r_ack        <= 1'b0;
            r_err        <= 1'b0;
            r_ovf        <= 1'b0;
            r_stat_ovf   <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_we         <= w_we_nxt;
            r_wdata      <= w_wdata_nxt;
            r_addr       <= w_addr_nxt;
            r_code       <= w_code_nxt;
            r_shadow     <= w_shadow_nxt;
            r_shadow_vld <= w_shadow_vld_nxt;
            r_m_valid    <= w_m_valid_nxt;
            r_m_data     <= w_m_data_nxt;
            r_s_ready    <= w_s_ready_nxt;
            r_rdata_lo   <= w_rdata_lo_nxt;
            r_rdata      <= w_rdata_nxt;
            r_ack        <= w_ack_nxt;
            r_err        <= w_err_nxt;
            r_ovf        <= w_ovf_nxt;
            r_stat_ovf   <= w_stat_ovf_nxt;
            r_abort      <= w_abort_nxt;
        end
    end

    assign wb_data_read = r_rdata;
    assign wb_ack       = r_ack;
    assign wb_err       = r_err;
    assign m_axis_valid = r_m_valid;
    assign m_axis_data  = r_m_data;
    assign s_axis_ready = r_s_ready;
    assign overflow     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_wb_axis_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_wb_axis_bridge
// Description : Directed plus randomized bench for wb_axis_bridge against a
//               transaction-level model of the address shadow and framing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_axis_bridge;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wb_cyc = 1'b0;
    logic          wb_stb = 1'b0;
    logic          wb_we = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [15:0]   wb_data_write = '0;
    logic [15:0]   wb_data_read;
    logic          wb_ack;
    logic          wb_err;
    logic          m_axis_valid;
    logic          m_axis_ready = 1'b0;
    logic [7:0]    m_axis_data;
    logic          s_axis_valid = 1'b0;
    logic          s_axis_ready;
    logic [7:0]    s_axis_data = '0;
    logic          overflow;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Transaction-level model of the remote address register
    logic [31:0] sh_val  = '0;
    bit          sh_vld  = 1'b0;
    logic [15:0] last_rd = '0;

    always #5 clk = ~clk;

    wb_axis_bridge #(
        .ADDR_WIDTH (AW),
        .POSTINC    (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_cyc        (wb_cyc),
        .wb_stb        (wb_stb),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .wb_data_write (wb_data_write),
        .wb_data_read  (wb_data_read),
        .wb_ack        (wb_ack),
        .wb_err        (wb_err),
        .m_axis_valid  (m_axis_valid),
        .m_axis_ready  (m_axis_ready),
        .m_axis_data   (m_axis_data),
        .s_axis_valid  (s_axis_valid),
        .s_axis_ready  (s_axis_ready),
        .s_axis_data   (s_axis_data),
        .overflow      (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_code(input logic [31:0] a);
        if (!sh_vld)                      return 2'd3;
        if (a == sh_val)                  return 2'd0;
        if ((a >> 8) == (sh_val >> 8))    return 2'd1;
        if ((a >> 16) == (sh_val >> 16))  return 2'd2;
        return 2'd3;
    endfunction

    task automatic txn(input bit we, input logic [31:0] addr, input logic [15:0] wd,
                       input logic [7:0] st, input logic [15:0] rd, input int rmode,
                       input bit drop, input string tag);
        logic [7:0]  exp_q[$];
        logic [7:0]  got_q[$];
        logic [7:0]  resp[3];
        logic [1:0]  code;
        logic [31:0] obs;
        bit          proto, errb, good, ready, v, pv, pr, ok;
        logic [7:0]  d, pd;
        int          nresp, hold_bad, gap, tmo;
        bit          started;

        code = exp_code(addr);
        exp_q.push_back({3'b000, code, 1'b1, we, 1'b0});
        if (code == 2'd3) begin
            exp_q.push_back(8'(addr >> 24));
            exp_q.push_back(8'(addr >> 16));
        end
        if (code >= 2'd2) exp_q.push_back(8'(addr >> 8));
        if (code >= 2'd1) exp_q.push_back(8'(addr));
        if (we) begin
            exp_q.push_back(8'(wd >> 8));
            exp_q.push_back(8'(wd));
        end

        proto = (st[0] != we) || ((st & 8'hF4) != 8'h00);
        errb  = st[1];
        good  = !proto && !errb;
        nresp = (good && !we) ? 3 : 1;
        resp[0] = st;
        resp[1] = rd[7:0];
        resp[2] = rd[15:8];

        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_data_write = wd;
        pv = 1'b0; pr = 1'b0; pd = '0; hold_bad = 0; gap = 0; started = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (s_axis_ready) break;
            if (pv && !pr && (!m_axis_valid || m_axis_data !== pd)) hold_bad++;
            if (started && !m_axis_valid) gap++;
            case (rmode)
                0:       ready = 1'b1;
                1:       ready = c[0];
                default: ready = 1'($urandom_range(0, 1));
            endcase
            m_axis_ready = ready;
            v = m_axis_valid;
            d = m_axis_data;
            if (v) started = 1'b1;
            if (drop && v) begin wb_cyc = 1'b0; wb_stb = 1'b0; end
            @(posedge clk); #1;
            if (v && ready) got_q.push_back(d);
            pv = v; pr = ready; pd = d;
        end
        m_axis_ready = 1'b0;

        check({tag, "_cmd_phase_done"}, 32'(s_axis_ready), 32'd1);
        check({tag, "_no_overlap"}, 32'(m_axis_valid), 32'd0);
        check({tag, "_hold_violations"}, 32'(hold_bad), 32'd0);
        check({tag, "_gaps"}, 32'(gap), 32'd0);
        check({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            obs = 'x;
            if (i < got_q.size()) obs = 32'(got_q[i]);
            check($sformatf("%s_byte%0d", tag, i), obs, 32'(exp_q[i]));
        end

        tmo = 0;
        for (int i = 0; i < nresp; i++) begin
            s_axis_valid = 1'b1;
            s_axis_data  = resp[i];
            ok = 1'b0;
            for (int w = 0; w < 20; w++) begin
                if (s_axis_ready) begin ok = 1'b1; break; end
                @(posedge clk); #1;
            end
            if (!ok) begin tmo++; break; end
            @(posedge clk); #1;
        end
        s_axis_valid = 1'b0;
        s_axis_data  = '0;

        sh_vld = good;
        sh_val = good ? {addr[31:8], 8'(addr[7:0] + 8'd1)} : addr;
        if (good && !we) last_rd = rd;

        check({tag, "_resp_timeout"}, 32'(tmo), 32'd0);
        check({tag, "_ack"}, 32'(wb_ack), 32'(good && !drop));
        check({tag, "_err"}, 32'(wb_err), 32'(!good && !drop));
        check({tag, "_overflow"}, 32'(overflow), 32'(st[3]));
        check({tag, "_s_ready_low"}, 32'(s_axis_ready), 32'd0);
        check({tag, "_rdata"}, 32'(wb_data_read), 32'(last_rd));

        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(posedge clk); #1;
        check({tag, "_pulse_end"}, {29'd0, wb_ack, wb_err, overflow}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        bit          we;
        logic [7:0]  st;
        int          sel;
        bit          drop;
        logic [7:0]  rsv[5];

        rsv[0] = 8'h04; rsv[1] = 8'h10; rsv[2] = 8'h20; rsv[3] = 8'h40; rsv[4] = 8'h80;

        repeat (2) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(m_axis_valid), 32'd0);
        check("rst_s_ready", 32'(s_axis_ready), 32'd0);
        check("rst_ack_err_ovf", {29'd0, wb_ack, wb_err, overflow}, 32'd0);
        check("rst_m_data", 32'(m_axis_data), 32'd0);
        check("rst_rdata", 32'(wb_data_read), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        txn(1'b1, 32'h1234_5678, 16'hBEEF, 8'h01, 16'h0000, 0, 1'b0, "wr_first");
        txn(1'b0, 32'h1234_5679, 16'h0000, 8'h00, 16'hABCD, 0, 1'b0, "rd_same");
        txn(1'b0, 32'h1234_0010, 16'h0000, 8'h00, 16'h1357, 0, 1'b0, "rd_code2");
        txn(1'b0, 32'h1234_0020, 16'h0000, 8'h00, 16'h2468, 0, 1'b0, "rd_code1");
        txn(1'b0, 32'h1234_0021, 16'h0000, 8'h02, 16'h0000, 0, 1'b0, "rd_err");
        txn(1'b1, 32'h1234_0022, 16'h5A5A, 8'h09, 16'h0000, 0, 1'b0, "wr_ovf");
        txn(1'b1, 32'h1234_0023, 16'hA5A5, 8'h00, 16'h0000, 0, 1'b0, "wr_bad_we");
        txn(1'b0, 32'h0000_0100, 16'h0000, 8'h04, 16'h0000, 0, 1'b0, "rd_rsvd");
        txn(1'b1, 32'hCAFE_0001, 16'h0F0F, 8'h01, 16'h0000, 1, 1'b0, "wr_toggle");
        txn(1'b0, 32'hCAFE_1000, 16'h0000, 8'h08, 16'h9876, 1, 1'b0, "rd_toggle_ovf");
        txn(1'b0, 32'hCAFE_1001, 16'h0000, 8'h00, 16'h7777, 0, 1'b1, "rd_drop");
        txn(1'b0, 32'hCAFE_1002, 16'h0000, 8'h00, 16'h3141, 0, 1'b0, "rd_after_drop");

        // Reset asserted while a command byte is being held
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 32'h0BAD_F00D;
        m_axis_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("midrst_valid_before", 32'(m_axis_valid), 32'd1);
        check("midrst_cmd_byte", 32'(m_axis_data), 32'({3'b000, exp_code(32'h0BAD_F00D), 3'b100}));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_m_valid", 32'(m_axis_valid), 32'd0);
        check("midrst_s_ready", 32'(s_axis_ready), 32'd0);
        check("midrst_ack_err_ovf", {29'd0, wb_ack, wb_err, overflow}, 32'd0);
        check("midrst_m_data", 32'(m_axis_data), 32'd0);
        check("midrst_rdata", 32'(wb_data_read), 32'd0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sh_vld = 1'b0;
        last_rd = '0;
        @(posedge clk); #1;
        txn(1'b0, 32'hCAFE_1003, 16'h0000, 8'h00, 16'h2718, 0, 1'b0, "rd_after_rst");

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       a = sh_val;
                1:       a = {sh_val[31:8], 8'($urandom)};
                2:       a = {sh_val[31:16], 16'($urandom)};
                default: a = $urandom;
            endcase
            we  = 1'($urandom_range(0, 1));
            st  = {7'd0, we};
            sel = $urandom_range(0, 7);
            case (sel)
                3:       st = st | 8'h08;
                4:       st = st | 8'h02;
                5:       st = st | 8'h0A;
                6:       st = st ^ 8'h01;
                7:       st = st | rsv[$urandom_range(0, 4)];
                default: st = st;
            endcase
            drop = ($urandom_range(0, 9) == 0);
            txn(we, a, 16'($urandom), st, 16'($urandom), $urandom_range(0, 2), drop,
                $sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
